priority_encoder_stream: RTL and testbench

- Parametrised, sequential successor to the fixed 4-to-2 encoder.
- Accepts an N-bit request vector over a valid/ready handshake and latches it.
- Emits the index of every set bit, one per output beat, in priority order, with a last flag.
- Sits between request-collecting logic (switch/button banks, interrupt lines) and a downstream consumer such as a display driver or scheduler.

---
 rtl/priority_encoder_stream_pkg.sv | 13 +
 rtl/priority_encoder_stream_priority_index.sv | 28 ++
 rtl/priority_encoder_stream.sv | 115 +++++++++++
 tb/tb_priority_encoder_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_stream_pkg.sv
// Shared types for the streaming priority encoder: FSM state encoding and
// the HIGH_FIRST parameter encodings.
package priority_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int PRIO_HIGH_FIRST = 1;
    localparam int PRIO_LOW_FIRST  = 0;

endpackage

// File: rtl/priority_encoder_stream_priority_index.sv
// Combinational priority pick: index of the highest (or lowest) set bit of vec,
// plus a flag saying whether any bit is set at all.
module priority_index #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic          high_first,
    output logic [IW-1:0] idx,
    output logic          any_set
);

    always_comb begin
        idx     = '0;
        any_set = |vec;
        // Last match wins, so the scan direction decides which end has priority.
        if (high_first) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: latches a request vector and emits one set-bit
// index per beat. Optional out_onehot port under PRIORITY_ENCODER_STREAM_ONEHOT_EN.
//
//   state | meaning
//   IDLE  | waiting for a request vector, in_ready=1
//   EMIT  | presenting beats for the latched vector
module priority_encoder_stream
    import priority_encoder_pkg::*;
#(
    parameter int N          = 8,
    parameter int HIGH_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_zero
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
    ,
    output logic [N-1:0]         out_onehot
`endif
);

    localparam int   IW        = $clog2(N);
    localparam logic PICK_HIGH = (HIGH_FIRST == PRIO_HIGH_FIRST);

    state_t         state, state_next;
    logic [N-1:0]   pending, pending_next;
    logic           zero_flag, zero_next;
    logic [IW-1:0]  sel_idx;
    logic           sel_any;
    logic [N-1:0]   sel_mask;
    logic [N-1:0]   rest;

    priority_index #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .vec        (pending),
        .high_first (PICK_HIGH),
        .idx        (sel_idx),
        .any_set    (sel_any)
    );

    assign sel_mask = N'(1) << sel_idx;
    assign rest     = pending & ~sel_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            zero_flag <= zero_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        zero_next    = zero_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_req;
                    zero_next    = (in_req == '0);
                    state_next   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!out_last) begin
                        pending_next = rest;
                    end else if (in_valid) begin
                        // Back-to-back: next vector replaces the finished one with no bubble.
                        pending_next = in_req;
                        zero_next    = (in_req == '0);
                    end else begin
                        pending_next = '0;
                        state_next   = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == EMIT);
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
        out_onehot = '0;
`endif
        if (state == EMIT) begin
            out_zero = zero_flag;
            out_last = zero_flag | (rest == '0);
            out_idx  = (zero_flag | !sel_any) ? '0 : sel_idx;
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
            out_onehot = (zero_flag | !sel_any) ? '0 : sel_mask;
`endif
        end
    end

    assign in_ready = !rst & ((state == IDLE) | (out_valid & out_ready & out_last));

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Bench for priority_encoder_stream: two instances (high-first and low-first)
// share stimulus; table vectors, hand sequences and random vectors vs a model.
module tb_priority_encoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_req;
    logic       out_ready;

    logic       in_ready_h, out_valid_h, last_h, zero_h;
    logic [2:0] idx_h;
    logic       in_ready_l, out_valid_l, last_l, zero_l;
    logic [2:0] idx_l;
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
    logic [7:0] oh_h, oh_l;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_encoder_stream #(.N(8), .HIGH_FIRST(1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .in_req(in_req),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_idx(idx_h),
        .out_last(last_h), .out_zero(zero_h)
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
        , .out_onehot(oh_h)
`endif
    );

    priority_encoder_stream #(.N(8), .HIGH_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_req(in_req),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_idx(idx_l),
        .out_last(last_l), .out_zero(zero_l)
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
        , .out_onehot(oh_l)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sends one vector and follows it to completion, checking every beat of
    // both instances against index lists built straight from the set bits.
    task automatic run_vec(input logic [7:0] v, input int stall_pct, input int hold_first,
                           output int beats, output int fh, output int fl);
        int  qh[$];
        int  ql[$];
        bit  zero;
        bit  rdy;
        int  pos;
        int  cyc;
        zero = (v == 8'h00);
        for (int i = 7; i >= 0; i--) if (v[i]) qh.push_back(i);
        for (int i = 0; i <= 7; i++) if (v[i]) ql.push_back(i);
        if (zero) begin
            qh.push_back(0);
            ql.push_back(0);
        end
        beats = 0;
        fh = -1;
        fl = -1;
        in_valid  = 1'b1;
        in_req    = v;
        out_ready = 1'b0;
        #1 chk("in_ready_idle", in_ready_h, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pos = 0;
        cyc = 0;
        while (pos < qh.size() && cyc < 200) begin
            in_req = 8'($urandom);
            chk("valid_h", out_valid_h, 1);
            chk("valid_l", out_valid_l, 1);
            chk("idx_h", idx_h, qh[pos]);
            chk("idx_l", idx_l, ql[pos]);
            chk("last_h", last_h, (pos == qh.size() - 1));
            chk("last_l", last_l, (pos == ql.size() - 1));
            chk("zero_h", zero_h, zero);
            chk("zero_l", zero_l, zero);
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
            chk("onehot_h", oh_h, zero ? 0 : (1 << qh[pos]));
            chk("onehot_l", oh_l, zero ? 0 : (1 << ql[pos]));
`endif
            if (pos == 0) begin
                fh = idx_h;
                fl = idx_l;
            end
            rdy = (cyc >= hold_first) && ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                pos++;
                if (out_valid_h || pos == qh.size()) beats++;
            end
            cyc++;
        end
        if (cyc >= 200) chk("beat_budget", cyc, 0);
        out_ready = 1'b0;
        chk("done_valid_h", out_valid_h, 0);
        chk("done_valid_l", out_valid_l, 0);
        #1 chk("done_in_ready", in_ready_h, 1);
    endtask

    typedef struct {
        logic [7:0] req;
        int         first_h;
        int         first_l;
        int         beats;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   beats, fh, fl;
        logic [7:0] v;

        tbl[0] = '{8'h05, 2, 0, 2};
        tbl[1] = '{8'h00, 0, 0, 1};
        tbl[2] = '{8'hC0, 7, 6, 2};
        tbl[3] = '{8'h81, 7, 0, 2};
        tbl[4] = '{8'h80, 7, 7, 1};
        tbl[5] = '{8'h01, 0, 0, 1};
        tbl[6] = '{8'hFF, 7, 0, 8};
        tbl[7] = '{8'h3C, 5, 2, 4};
        tbl[8] = '{8'hA5, 7, 0, 4};

        rst = 1'b1;
        in_valid = 1'b0;
        in_req = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid_h, 0);
        chk("rst_in_ready", in_ready_h, 0);
        chk("rst_idx", idx_h, 0);
        chk("rst_last", last_h, 0);
        chk("rst_zero", zero_h, 0);
`ifdef PRIORITY_ENCODER_STREAM_ONEHOT_EN
        chk("rst_onehot", oh_h, 0);
`endif
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready_h, 1);
        @(negedge clk);

        foreach (tbl[i]) begin
            run_vec(tbl[i].req, 0, 0, beats, fh, fl);
            chk("tbl_first_h", fh, tbl[i].first_h);
            chk("tbl_first_l", fl, tbl[i].first_l);
            chk("tbl_beats", beats, tbl[i].beats);
        end

        // Stall: three cycles with out_ready low on the first beat of 0xC0.
        run_vec(8'hC0, 0, 3, beats, fh, fl);
        chk("stall_beats", beats, 2);

        // Back-to-back: next vector offered during the last beat of 0x81.
        in_valid = 1'b1;
        in_req = 8'h81;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("b2b_idx_h0", idx_h, 7);
        chk("b2b_idx_l0", idx_l, 0);
        chk("b2b_last0", last_h, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idx_h1", idx_h, 0);
        chk("b2b_idx_l1", idx_l, 7);
        chk("b2b_last1", last_h, 1);
        in_valid = 1'b1;
        in_req = 8'h08;
        #1 chk("b2b_in_ready", in_ready_h, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_valid", out_valid_h, 1);
        chk("b2b_idx_h2", idx_h, 3);
        chk("b2b_idx_l2", idx_l, 3);
        chk("b2b_last2", last_l, 1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_done", out_valid_h, 0);

        // Reset during the first beat of 0xFF discards the vector.
        in_valid = 1'b1;
        in_req = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_idx_h", idx_h, 7);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_valid_h", out_valid_h, 0);
        chk("mid_valid_l", out_valid_l, 0);
        chk("mid_in_ready", in_ready_h, 0);
        rst = 1'b0;
        #1 chk("mid_rel_ready", in_ready_h, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_no_stale", out_valid_h | out_valid_l, 0);
        end
        out_ready = 1'b0;

        for (int n = 0; n < 30; n++) begin
            v = 8'($urandom) & 8'($urandom);
            if (n % 7 == 0) v = 8'h00;
            run_vec(v, 30, 0, beats, fh, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
